// File: rtl/midi_pkg.sv
// Shared constants, state types and helpers for the MIDI note decoder.
// Imported by midi_uart_rx and midi_note_decoder.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    P_WAIT_STATUS,
    P_WAIT_KEY,
    P_WAIT_VEL
  } parser_state_e;

  function automatic logic is_chan_msg(
    input logic [7:0] b,
    input logic [3:0] nib,
    input logic [3:0] ch
  );
    return b == {nib, ch};
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, start-glitch reject.
// Ports: clk, reset_n, midi_rx in; byte_out, byte_valid, framing_err out.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       midi_rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic          rx_s;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;
  logic          tick;

  assign rx_s = sync2_q;
  // Counter reaching zero marks the sample point of the current bit.
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      U_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = U_START;
          cnt_d   = HALF;
        end
      end
      U_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          state_d = U_IDLE;
        end else begin
          state_d = U_DATA;
          cnt_d   = FULL;
          idx_d   = 3'd0;
        end
      end
      U_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = U_STOP;
          end
        end
      end
      U_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Back to IDLE mid stop bit so a
          // back-to-back start edge is seen.
          state_d = U_IDLE;
          bv_d    = rx_s;
          fe_d    = !rx_s;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= U_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync1_q <= midi_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  assign byte_out    = shift_q;
  assign byte_valid  = bv_q;
  assign framing_err = fe_q;

endmodule

// File: rtl/midi_note_decoder.sv
// Monophonic last-note-priority MIDI Note On/Off decoder for one channel.
// Ports: clk, reset_n, midi_rx in; cmd_out, cmd_valid, note_active, framing_err out.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int          CLK_HZ  = 50_000_000,
  parameter int          BAUD    = 31250,
  parameter logic [3:0]  CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        midi_rx,
  output logic [15:0] cmd_out,
  output logic        cmd_valid,
  output logic        note_active,
  output logic        framing_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_ferr;

  parser_state_e p_q, p_d;
  logic [7:0]    rs_q, rs_d;
  logic [6:0]    key_q, key_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          act_q, act_d;
  logic          val_q, val_d;

  logic          is_rt;
  logic          is_ours;
  logic          is_stat;
  logic          note_on;
  logic [6:0]    vel;

  midi_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .midi_rx    (midi_rx),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid),
    .framing_err(rx_ferr)
  );

  assign is_rt   = (rx_byte >= RT_MIN);
  assign is_stat = rx_byte[7] && !is_rt;
  assign is_ours =
    is_chan_msg(rx_byte, NOTE_ON, CHANNEL) ||
    is_chan_msg(rx_byte, NOTE_OFF, CHANNEL);
  assign note_on = (rs_q == {NOTE_ON, CHANNEL});
  assign vel     = rx_byte[6:0];

  always_comb begin
    p_d   = p_q;
    rs_d  = rs_q;
    key_d = key_q;
    cmd_d = cmd_q;
    act_d = act_q;
    val_d = 1'b0;
    if (rx_ferr) begin
      p_d  = P_WAIT_STATUS;
      rs_d = 8'h00;
    end else if (rx_valid) begin
      unique case (1'b1)
        is_rt: begin
        end
        is_stat && is_ours: begin
          rs_d = rx_byte;
          p_d  = P_WAIT_KEY;
        end
        is_stat && !is_ours: begin
          rs_d = 8'h00;
          p_d  = P_WAIT_STATUS;
        end
        !rx_byte[7]: begin
          unique case (p_q)
            P_WAIT_KEY: begin
              key_d = rx_byte[6:0];
              p_d   = P_WAIT_VEL;
            end
            P_WAIT_VEL: begin
              p_d = P_WAIT_KEY;
              if (note_on && vel != 7'd0) begin
                cmd_d = {1'b0, key_q, 1'b0, vel};
                act_d = 1'b1;
                val_d = 1'b1;
              end else if (act_q &&
                           key_q == cmd_q[14:8]) begin
                cmd_d = 16'h0000;
                act_d = 1'b0;
                val_d = 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q   <= P_WAIT_STATUS;
      rs_q  <= 8'h00;
      key_q <= 7'd0;
      cmd_q <= 16'h0000;
      act_q <= 1'b0;
      val_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      rs_q  <= rs_d;
      key_q <= key_d;
      cmd_q <= cmd_d;
      act_q <= act_d;
      val_q <= val_d;
    end
  end

  assign cmd_out     = cmd_q;
  assign cmd_valid   = val_q;
  assign note_active = act_q;
  assign framing_err = rx_ferr;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed self-checking bench for midi_note_decoder.
// Runs at 40 clocks per bit to keep the simulation short.
module tb_midi_note_decoder;

  localparam int CLK_HZ = 1_250_000;
  localparam int BAUD   = 31250;
  localparam int CPB    = CLK_HZ / BAUD;

  logic        clk;
  logic        reset_n;
  logic        midi_rx;
  logic [15:0] cmd_out;
  logic        cmd_valid;
  logic        note_active;
  logic        framing_err;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int fcnt   = 0;

  midi_note_decoder #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .CHANNEL(4'd0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .midi_rx    (midi_rx),
    .cmd_out    (cmd_out),
    .cmd_valid  (cmd_valid),
    .note_active(note_active),
    .framing_err(framing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) vcnt++;
    if (framing_err === 1'b1) fcnt++;
  end

  task automatic send_bit(input logic v);
    midi_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (!stop) send_bit(1'b1);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    settle();
    checks++;
    if (cmd_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_cmd got %h want 0000", cmd_out);
    end
    checks++;
    if ({cmd_valid, note_active, framing_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {cmd_valid, note_active, framing_err});
    end
  endtask

  task automatic test_on_off();
    int v0;
    v0 = vcnt;
    send_byte(8'h90); send_byte(8'h3F); send_byte(8'h64);
    settle();
    checks++;
    if (cmd_out !== 16'h3F64 || note_active !== 1'b1 ||
        vcnt != v0 + 1) begin
      errors++;
      $display("FAIL on got %h act %b pulses %0d want 3F64 1 1",
               cmd_out, note_active, vcnt - v0);
    end
    send_byte(8'h80); send_byte(8'h3F); send_byte(8'h00);
    settle();
    checks++;
    if (cmd_out !== 16'h0000 || note_active !== 1'b0 ||
        vcnt != v0 + 2) begin
      errors++;
      $display("FAIL off got %h act %b pulses %0d want 0000 0 2",
               cmd_out, note_active, vcnt - v0);
    end
  endtask

  task automatic test_running_status();
    int v0;
    v0 = vcnt;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    settle();
    checks++;
    if (cmd_out !== 16'h3C40 || vcnt != v0 + 1) begin
      errors++;
      $display("FAIL rs1 got %h pulses %0d want 3C40 1",
               cmd_out, vcnt - v0);
    end
    send_byte(8'h3E); send_byte(8'h50);
    settle();
    checks++;
    if (cmd_out !== 16'h3E50 || vcnt != v0 + 2) begin
      errors++;
      $display("FAIL rs2 got %h pulses %0d want 3E50 2",
               cmd_out, vcnt - v0);
    end
    send_byte(8'h3E); send_byte(8'h00);
    settle();
    checks++;
    if (cmd_out !== 16'h0000 || note_active !== 1'b0 ||
        vcnt != v0 + 3) begin
      errors++;
      $display("FAIL rs_vel0 got %h act %b pulses %0d want 0000 0 3",
               cmd_out, note_active, vcnt - v0);
    end
  endtask

  task automatic test_off_other_key();
    int v0;
    v0 = vcnt;
    send_byte(8'h90); send_byte(8'h40); send_byte(8'h7F);
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
    settle();
    checks++;
    if (cmd_out !== 16'h407F || note_active !== 1'b1 ||
        vcnt != v0 + 1) begin
      errors++;
      $display("FAIL off_other got %h act %b pulses %0d want 407F 1 1",
               cmd_out, note_active, vcnt - v0);
    end
  endtask

  task automatic test_channel_realtime();
    int v0;
    v0 = vcnt;
    send_byte(8'h91); send_byte(8'h3F); send_byte(8'h64);
    settle();
    checks++;
    if (cmd_out !== 16'h407F || vcnt != v0) begin
      errors++;
      $display("FAIL other_chan got %h pulses %0d want 407F 0",
               cmd_out, vcnt - v0);
    end
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3F);
    send_byte(8'hFE); send_byte(8'h64);
    settle();
    checks++;
    if (cmd_out !== 16'h3F64 || vcnt != v0 + 1) begin
      errors++;
      $display("FAIL realtime got %h pulses %0d want 3F64 1",
               cmd_out, vcnt - v0);
    end
  endtask

  task automatic test_framing();
    int v0;
    int f0;
    send_byte(8'h80); send_byte(8'h3F); send_byte(8'h00);
    settle();
    v0 = vcnt;
    f0 = fcnt;
    send_byte(8'h90); send_byte(8'h3F);
    send_byte(8'h64, 1'b0);
    settle();
    checks++;
    if (fcnt != f0 + 1 || vcnt != v0 || cmd_out !== 16'h0000) begin
      errors++;
      $display("FAIL ferr got ferr %0d pulses %0d cmd %h want 1 0 0000",
               fcnt - f0, vcnt - v0, cmd_out);
    end
    send_byte(8'h64);
    settle();
    checks++;
    if (vcnt != v0 || cmd_out !== 16'h0000) begin
      errors++;
      $display("FAIL ferr_drop got pulses %0d cmd %h want 0 0000",
               vcnt - v0, cmd_out);
    end
    send_byte(8'h90); send_byte(8'h3F); send_byte(8'h64);
    settle();
    checks++;
    if (cmd_out !== 16'h3F64 || vcnt != v0 + 1 ||
        fcnt != f0 + 1) begin
      errors++;
      $display("FAIL ferr_recover got %h pulses %0d ferr %0d want 3F64 1 1",
               cmd_out, vcnt - v0, fcnt - f0);
    end
  endtask

  task automatic test_glitch();
    int v0;
    int f0;
    v0 = vcnt;
    f0 = fcnt;
    // Low pulse well short of half a bit period.
    midi_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    midi_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    #1;
    checks++;
    if (vcnt != v0 || fcnt != f0 || cmd_out !== 16'h3F64) begin
      errors++;
      $display("FAIL glitch got pulses %0d ferr %0d cmd %h want 0 0 3F64",
               vcnt - v0, fcnt - f0, cmd_out);
    end
  endtask

  task automatic test_reset_mid_msg();
    int v0;
    send_byte(8'h90); send_byte(8'h40);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    reset_n = 1'b0;
    midi_rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (cmd_out !== 16'h0000 ||
        {cmd_valid, note_active, framing_err} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset got %h flags %b want 0000 000",
               cmd_out, {cmd_valid, note_active, framing_err});
    end
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    v0 = vcnt;
    send_byte(8'h7F);
    settle();
    checks++;
    if (cmd_out !== 16'h0000 || vcnt != v0) begin
      errors++;
      $display("FAIL post_reset_data got %h pulses %0d want 0000 0",
               cmd_out, vcnt - v0);
    end
    send_byte(8'h90); send_byte(8'h3F); send_byte(8'h64);
    settle();
    checks++;
    if (cmd_out !== 16'h3F64 || note_active !== 1'b1 ||
        vcnt != v0 + 1) begin
      errors++;
      $display("FAIL post_reset got %h act %b pulses %0d want 3F64 1 1",
               cmd_out, note_active, vcnt - v0);
    end
  endtask

  initial begin
    midi_rx = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_on_off();
    test_running_status();
    test_off_other_key();
    test_channel_realtime();
    test_framing();
    test_glitch();
    test_reset_mid_msg();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
